multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM that sequences a multicycle RV32I datapath through fetch, decode, execute, memory and writeback.
- The datapath shares one memory for instruction and data, one ALU, and holding registers IR, oldPC, ALUOut and MDR.
- Generates every enable and mux select. Stalls on memory handshake. Halts on illegal instructions.
- Sits beside the datapath, replacing the single-cycle combinational decoder.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset; state forced to RESET_STATE while low
- op  input  7  IR[6:0]
- func3  input  3  IR[14:12]
- func7  input  7  IR[31:25]
- zero  input  1  ALU zero flag
- neg  input  1  ALU result bit 31
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  PC <= result
- adr_src  output  1  memory address: 0 PC, 1 ALUOut
- ir_write  output  1  IR <= mem data, oldPC <= PC
- mem_write  output  1  memory write strobe
- reg_write  output  1  register-file write
- result_src  output  2  00 ALUOut, 01 MDR, 10 ALU result
- alu_src_a  output  2  00 PC, 01 oldPC, 10 RD1, 11 zero
- alu_src_b  output  2  00 RD2, 01 imm, 10 const 4
- imm_src  output  3  000 I, 001 S, 010 B, 011 J, 100 U
- alu_op  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor
- illegal  output  1  high in HALT
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction
- state  output  4  current state, for debug

Behaviour:
- Reset behaviour
  - rst low: state=FETCH.
  - All enables (pc_write, ir_write, reg_write, mem_write, instr_done) forced to 0 combinationally while rst is low.
  - illegal=0.
- Output style
  - Moore outputs, except three: FETCH/MEM strobes gated by mem_ready, BRANCH pc_write, and alu_op decode.
  - Any select not listed for a state is 00. Any enable not listed is 0.
- imm_src is decoded combinationally from op in every state:
  - 0100011 -> S
  - 1100011 -> B
  - 1101111 -> J
  - 0110111 -> U
  - else -> I
- State encodings, outputs and transitions:
  - 0 FETCH: adr_src=0, a=00, b=10, add, result_src=10. pc_write=ir_write=mem_ready. Stay while !mem_ready, else -> DECODE.
  - 1 DECODE: a=01, b=01, add (ALUOut=oldPC+imm). Next state by op:
    - 0000011 or 0100011 -> MEM_ADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JUMP
    - 1100111 -> JALR_ADR
    - 0110111 -> LUI
    - else, or an unsupported func3 -> HALT
  - 2 MEM_ADR: a=10, b=01, add. lw -> MEM_RD, sw -> MEM_WR.
  - 3 MEM_RD: adr_src=1. Stay while !mem_ready, else -> MEM_WB.
  - 4 MEM_WB: result_src=01, reg_write=1, instr_done=1 -> FETCH.
  - 5 MEM_WR: adr_src=1, mem_write=1 held until mem_ready; instr_done=mem_ready; -> FETCH on mem_ready.
  - 6 EXEC_R: a=10, b=00 -> ALU_WB.
  - 7 EXEC_I: a=10, b=01 -> ALU_WB.
  - 8 ALU_WB: result_src=00, reg_write=1, instr_done=1 -> FETCH.
  - 9 BRANCH: a=10, b=00, sub, result_src=00, pc_write=taken, instr_done=1 -> FETCH.
    - taken = beq: zero; bne: !zero; blt: neg; bge: !neg.
  - 10 JALR_ADR: a=10, b=01, add -> JUMP.
  - 11 JUMP: a=01, b=10, add, result_src=00, pc_write=1 -> ALU_WB. The PC takes the old ALUOut target; ALUOut captures oldPC+4 for rd.
  - 12 LUI: a=11, b=01, add -> ALU_WB.
  - 15 HALT: illegal=1, all enables 0. Exit only by reset.
  - Unused encodings go to HALT.
- alu_op decode for EXEC_R/EXEC_I, by func3:
  - 000: add; sub only when EXEC_R and func7[5]=1.
  - 111: and
  - 110: or
  - 010: slt
  - 100: xor
  - Other func3 values are illegal. Branch func3 in {010, 011, 110, 111} is illegal.
- Latency, with zero memory wait:
  - R/I/LUI: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
  - jal: 4 cycles
  - jalr: 5 cycles
- Each extra wait cycle on mem_ready adds one cycle. No strobe or select changes while stalled.
- rst asserted mid-instruction aborts it. No partial write fires after reset asserts.

Test Plan:
- Reset with mem_ready=1, add x3,x1,x2 (op=0110011, f3=000, f7=0) -> states 0,1,6,8,0; alu_op=000; reg_write only in state 8; instr_done one pulse.
- sub (f7=0100000) -> alu_op=001 in EXEC_R. addi with f7[5]=1 -> alu_op=000.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEM_RD -> 10 cycles total; pc_write/ir_write asserted exactly once.
- sw -> mem_write high through MEM_WR until mem_ready; reg_write never asserted.
- beq with zero=1 -> pc_write=1 in BRANCH; zero=0 -> 0. blt with neg=1 -> taken. bge with neg=1 -> not taken.
- jalr then op=1111111 -> states 0,1,10,11,8 with pc_write in 11; next instruction enters HALT, illegal=1, and stays there until rst low.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I datapath: sequences fetch/decode/execute/memory/writeback,
// drives every enable and mux select, stalls on the memory handshake and halts on illegal opcodes.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADR  = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALU_WB   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JALR_ADR = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_LUI      = 4'd12;
  localparam logic [3:0] S_HALT     = 4'd15;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [2:0] w_alu_func;
  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_instr_done;
  logic       w_unused_func7;

  assign w_unused_func7 = ^{func7[6], func7[4:0]};

  function automatic logic alu_f3_ok(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b111, 3'b110, 3'b010, 3'b100: alu_f3_ok = 1'b1;
      default:                                 alu_f3_ok = 1'b0;
    endcase
  endfunction

  function automatic logic br_f3_ok(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b100, 3'b101: br_f3_ok = 1'b1;
      default:                         br_f3_ok = 1'b0;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic n);
    case (f3)
      3'b000:  br_taken = z;
      3'b001:  br_taken = ~z;
      3'b100:  br_taken = n;
      3'b101:  br_taken = ~n;
      default: br_taken = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] decode_target(input logic [6:0] opc, input logic [2:0] f3);
    case (opc)
      OP_LOAD, OP_STORE: decode_target = S_MEM_ADR;
      OP_R:              decode_target = alu_f3_ok(f3) ? S_EXEC_R : S_HALT;
      OP_I:              decode_target = alu_f3_ok(f3) ? S_EXEC_I : S_HALT;
      OP_BR:             decode_target = br_f3_ok(f3) ? S_BRANCH : S_HALT;
      OP_JAL:            decode_target = S_JUMP;
      OP_JALR:           decode_target = S_JALR_ADR;
      OP_LUI:            decode_target = S_LUI;
      default:           decode_target = S_HALT;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = S_HALT;
    case (r_state)
      S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   w_next_state = decode_target(op, func3);
      S_MEM_ADR:  w_next_state = (op == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next_state = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   w_next_state = S_FETCH;
      S_MEM_WR:   w_next_state = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   w_next_state = S_ALU_WB;
      S_EXEC_I:   w_next_state = S_ALU_WB;
      S_ALU_WB:   w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = S_FETCH;
      S_JALR_ADR: w_next_state = S_JUMP;
      S_JUMP:     w_next_state = S_ALU_WB;
      S_LUI:      w_next_state = S_ALU_WB;
      S_HALT:     w_next_state = S_HALT;
      default:    w_next_state = S_HALT;
    endcase
  end

  // ALU function for EXEC_R/EXEC_I; sub only for register-register with func7[5]
  always_comb begin
    w_alu_func = 3'b000;
    case (func3)
      3'b000:  w_alu_func = ((r_state == S_EXEC_R) && func7[5]) ? 3'b001 : 3'b000;
      3'b111:  w_alu_func = 3'b010;
      3'b110:  w_alu_func = 3'b011;
      3'b010:  w_alu_func = 3'b100;
      3'b100:  w_alu_func = 3'b101;
      default: w_alu_func = 3'b000;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    imm_src = 3'b000;
    case (op)
      OP_STORE: imm_src = 3'b001;
      OP_BR:    imm_src = 3'b010;
      OP_JAL:   imm_src = 3'b011;
      OP_LUI:   imm_src = 3'b100;
      default:  imm_src = 3'b000;
    endcase
  end

  // Per-state selects and ungated enables
  always_comb begin
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_instr_done = 1'b0;
    adr_src      = 1'b0;
    result_src   = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 3'b000;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        w_pc_write = mem_ready;
        w_ir_write = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEM_RD: adr_src = 1'b1;
      S_MEM_WB: begin
        result_src   = 2'b01;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEM_WR: begin
        adr_src      = 1'b1;
        w_mem_write  = 1'b1;
        w_instr_done = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = w_alu_func;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = w_alu_func;
      end
      S_ALU_WB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a    = 2'b10;
        alu_op       = 3'b001;
        w_pc_write   = br_taken(func3, zero, neg);
        w_instr_done = 1'b1;
      end
      S_JALR_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      // PC takes the target already in ALUOut while ALUOut captures oldPC+4 for rd
      S_JUMP: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        w_pc_write = 1'b1;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      default: begin
        w_pc_write = 1'b0;
      end
    endcase
  end

  // Enables are killed the instant reset asserts so an aborted access never writes
  assign pc_write   = w_pc_write & rst;
  assign ir_write   = w_ir_write & rst;
  assign mem_write  = w_mem_write & rst;
  assign reg_write  = w_reg_write & rst;
  assign instr_done = w_instr_done & rst;
  assign illegal    = (r_state == S_HALT) & rst;
  assign state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench: each instruction is expanded into an expected per-cycle
// trace (state, handshake, enables, selects) from its class, then replayed against the DUT.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] func3 = 3'd0;
  logic [6:0] func7 = 7'd0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal, instr_done;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src, alu_op;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic        rdy;
    logic [5:0]  en;   // {pc_write, ir_write, reg_write, mem_write, instr_done, illegal}
    logic [12:0] sel;  // {adr_src, result_src, a, b, alu_op, imm_src}
  } step_t;

  step_t exp_q[$];

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JAL = 5, K_JALR = 6,
                 K_LUI = 7, K_BAD = 8;

  multicycle_controller #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero), .neg(neg),
    .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_op(alu_op),
    .illegal(illegal), .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] dut_en();
    return {pc_write, ir_write, reg_write, mem_write, instr_done, illegal};
  endfunction

  function automatic logic [12:0] dut_sel();
    return {adr_src, result_src, alu_src_a, alu_src_b, alu_op, imm_src};
  endfunction

  task automatic add_step(input logic [3:0] st, input logic rdy, input logic [5:0] en,
                          input logic [12:0] sel);
    step_t s;
    s.st = st; s.rdy = rdy; s.en = en; s.sel = sel;
    exp_q.push_back(s);
  endtask

  // Called at a falling edge; leaves the DUT in FETCH at a falling edge with rst released
  task automatic do_reset();
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_enables", 32'(dut_en()), 32'd0);
    @(negedge clk);
    #1;
    chk("reset_hold_state", 32'(state), 32'd0);
    chk("reset_hold_enables", 32'(dut_en()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // abort: -1 none, -2 random cycle, >=0 assert reset on that cycle of the trace
  task automatic run_instr(input logic [6:0] i_op, input logic [2:0] f3, input logic [6:0] f7,
                           input int wf, input int wm, input logic z, input logic n,
                           input int abort);
    logic [2:0] imm;
    logic [2:0] aop;
    logic       tk;
    int         kind;
    int         abort_at;
    logic [12:0] wb_sel;
    case (i_op)
      7'b0100011: imm = 3'b001;
      7'b1100011: imm = 3'b010;
      7'b1101111: imm = 3'b011;
      7'b0110111: imm = 3'b100;
      default:    imm = 3'b000;
    endcase
    case (i_op)
      7'b0110011: kind = K_R;
      7'b0010011: kind = K_I;
      7'b0000011: kind = K_LW;
      7'b0100011: kind = K_SW;
      7'b1100011: kind = K_BR;
      7'b1101111: kind = K_JAL;
      7'b1100111: kind = K_JALR;
      7'b0110111: kind = K_LUI;
      default:    kind = K_BAD;
    endcase
    if ((kind == K_R || kind == K_I) && !(f3 inside {3'd0, 3'd7, 3'd6, 3'd2, 3'd4})) kind = K_BAD;
    if (kind == K_BR && !(f3 inside {3'd0, 3'd1, 3'd4, 3'd5})) kind = K_BAD;
    case (f3)
      3'd0:    aop = (kind == K_R && f7[5]) ? 3'd1 : 3'd0;
      3'd7:    aop = 3'd2;
      3'd6:    aop = 3'd3;
      3'd2:    aop = 3'd4;
      default: aop = 3'd5;
    endcase
    tk = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? n : !n;
    wb_sel = {1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm};

    exp_q.delete();
    for (int k = 0; k < wf; k++) add_step(4'd0, 1'b0, 6'b000000, {1'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm});
    add_step(4'd0, 1'b1, 6'b110000, {1'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm});
    add_step(4'd1, rbit(), 6'b000000, {1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm});
    case (kind)
      K_R, K_I: begin
        add_step((kind == K_R) ? 4'd6 : 4'd7, rbit(), 6'b000000,
                 {1'b0, 2'b00, 2'b10, (kind == K_R) ? 2'b00 : 2'b01, aop, imm});
        add_step(4'd8, rbit(), 6'b001010, wb_sel);
      end
      K_LW: begin
        add_step(4'd2, rbit(), 6'b000000, {1'b0, 2'b00, 2'b10, 2'b01, 3'b000, imm});
        for (int k = 0; k < wm; k++) add_step(4'd3, 1'b0, 6'b000000, {1'b1, 12'(imm)});
        add_step(4'd3, 1'b1, 6'b000000, {1'b1, 12'(imm)});
        add_step(4'd4, rbit(), 6'b001010, {1'b0, 2'b01, 2'b00, 2'b00, 3'b000, imm});
      end
      K_SW: begin
        add_step(4'd2, rbit(), 6'b000000, {1'b0, 2'b00, 2'b10, 2'b01, 3'b000, imm});
        for (int k = 0; k < wm; k++) add_step(4'd5, 1'b0, 6'b000100, {1'b1, 12'(imm)});
        add_step(4'd5, 1'b1, 6'b000110, {1'b1, 12'(imm)});
      end
      K_BR: add_step(4'd9, rbit(), {tk, 5'b00010}, {1'b0, 2'b00, 2'b10, 2'b00, 3'b001, imm});
      K_JAL, K_JALR: begin
        if (kind == K_JALR) add_step(4'd10, rbit(), 6'b000000, {1'b0, 2'b00, 2'b10, 2'b01, 3'b000, imm});
        add_step(4'd11, rbit(), 6'b100000, {1'b0, 2'b00, 2'b01, 2'b10, 3'b000, imm});
        add_step(4'd8, rbit(), 6'b001010, wb_sel);
      end
      K_LUI: begin
        add_step(4'd12, rbit(), 6'b000000, {1'b0, 2'b00, 2'b11, 2'b01, 3'b000, imm});
        add_step(4'd8, rbit(), 6'b001010, wb_sel);
      end
      default: for (int k = 0; k < 4; k++) add_step(4'd15, rbit(), 6'b000001, wb_sel);
    endcase

    abort_at = (abort == -2) ? int'($urandom_range(0, exp_q.size() - 1)) : abort;
    for (int i = 0; i < exp_q.size(); i++) begin
      op = i_op; func3 = f3; func7 = f7; zero = z; neg = n;
      mem_ready = exp_q[i].rdy;
      if (i == abort_at) begin
        rst = 1'b0;
        #1;
        chk($sformatf("abort_state op=%b i=%0d", i_op, i), 32'(state), 32'd0);
        chk($sformatf("abort_enables op=%b i=%0d", i_op, i), 32'(dut_en()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      #1;
      chk($sformatf("state op=%b f3=%0d i=%0d", i_op, f3, i), 32'(state), 32'(exp_q[i].st));
      chk($sformatf("enables op=%b f3=%0d i=%0d", i_op, f3, i), 32'(dut_en()), 32'(exp_q[i].en));
      chk($sformatf("selects op=%b f3=%0d i=%0d", i_op, f3, i), 32'(dut_sel()), 32'(exp_q[i].sel));
      @(negedge clk);
    end
    if (kind == K_BAD) do_reset();
  endtask

  logic [6:0] op_tab [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010011, 7'b0000000};

  initial begin
    @(negedge clk);
    do_reset();
    run_instr(7'b0110011, 3'd0, 7'b0000000, 0, 0, 1'b0, 1'b0, -1);  // add
    run_instr(7'b0110011, 3'd0, 7'b0100000, 0, 0, 1'b0, 1'b0, -1);  // sub
    run_instr(7'b0010011, 3'd0, 7'b0100000, 0, 0, 1'b0, 1'b0, -1);  // addi, f7[5] ignored
    run_instr(7'b0000011, 3'd2, 7'b0000000, 2, 3, 1'b0, 1'b0, -1);  // lw, 10 cycles
    run_instr(7'b0100011, 3'd2, 7'b0000000, 1, 2, 1'b0, 1'b0, -1);  // sw with stalls
    run_instr(7'b1100011, 3'd0, 7'b0000000, 0, 0, 1'b1, 1'b0, -1);  // beq taken
    run_instr(7'b1100011, 3'd0, 7'b0000000, 0, 0, 1'b0, 1'b0, -1);  // beq not taken
    run_instr(7'b1100011, 3'd4, 7'b0000000, 0, 0, 1'b0, 1'b1, -1);  // blt taken
    run_instr(7'b1100011, 3'd5, 7'b0000000, 0, 0, 1'b0, 1'b1, -1);  // bge not taken
    run_instr(7'b1100111, 3'd0, 7'b0000000, 0, 0, 1'b0, 1'b0, -1);  // jalr
    run_instr(7'b1111111, 3'd0, 7'b0000000, 0, 0, 1'b0, 1'b0, -1);  // illegal -> HALT
    run_instr(7'b0110011, 3'd3, 7'b0000000, 0, 0, 1'b0, 1'b0, -1);  // sltu unsupported
    run_instr(7'b1100011, 3'd6, 7'b0000000, 0, 0, 1'b0, 1'b0, -1);  // bltu unsupported
    run_instr(7'b0100011, 3'd2, 7'b0000000, 0, 2, 1'b0, 1'b0, 5);   // reset during sw strobe
    run_instr(7'b0110111, 3'd0, 7'b0000000, 0, 0, 1'b0, 1'b0, -1);  // lui after abort
    for (int t = 0; t < 300; t++) begin
      logic [6:0] r_op;
      int idx;
      idx = int'($urandom_range(0, 9));
      r_op = (idx == 9) ? 7'($urandom_range(0, 127)) : op_tab[idx];
      run_instr(r_op, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rbit(), rbit(),
                ($urandom_range(0, 9) == 0) ? -2 : -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
